// File: rtl/mtx_hop_sched.sv
// Frequency-hop scheduler: steps a signal generator through a table of phase
// increments, separated by programmable gaps, optionally gated by an external
// trigger and optionally repeating frames.
module mtx_hop_sched #(
  parameter int PHASE_WIDTH = 24,
  parameter int NHOP_WIDTH  = 6,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic                   trig_in,
  input  logic                   hop_ready,
  output logic                   gen_srst,
  output logic [PHASE_WIDTH-1:0] hop_ph_inc,
  output logic [NHOP_WIDTH-1:0]  hop_idx,
  output logic                   tx_active,
  output logic                   sync_out,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int DEPTH = 2 ** NHOP_WIDTH;
  localparam logic [NHOP_WIDTH:0] NUM_MAX = {1'b1, {NHOP_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GAP,
    S_LOAD,
    S_HOP
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt;
  logic [2:0]             r_ctrl;
  logic [NHOP_WIDTH:0]    r_num_hops;
  logic [CNT_WIDTH-1:0]   r_gap_len;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [PHASE_WIDTH-1:0] r_table [0:DEPTH-1];
  logic                   r_trig_s1;
  logic                   r_trig_s2;
  logic                   r_trig_s3;
  logic                   r_trig_evt;

  logic                   w_wr_ctrl;
  logic                   w_wr_num;
  logic                   w_wr_gap;
  logic                   w_tbl_hit;
  logic [NHOP_WIDTH-1:0]  w_tbl_idx;
  logic [NHOP_WIDTH:0]    w_num_sel;
  logic [NHOP_WIDTH:0]    w_num_new;
  logic [CNT_WIDTH-1:0]   w_gap_sel;
  logic [CNT_WIDTH-1:0]   w_gap_new;
  logic                   w_en;
  logic                   w_trig_mode;
  logic                   w_cont;
  logic                   w_last;
  logic                   w_unused;

  assign w_unused = ^set_data;

  assign w_wr_ctrl = set_stb && (set_addr == 8'd0);
  assign w_wr_num  = set_stb && (set_addr == 8'd1);
  assign w_wr_gap  = set_stb && (set_addr == 8'd2);
  assign w_tbl_hit = set_stb && (set_addr >= 8'd64) && ({1'b0, set_addr} < 9'(64 + DEPTH));
  assign w_tbl_idx = NHOP_WIDTH'(set_addr - 8'd64);
  assign w_num_sel = set_data[NHOP_WIDTH:0];
  assign w_gap_sel = set_data[CNT_WIDTH-1:0];

  assign w_en        = r_ctrl[0];
  assign w_trig_mode = r_ctrl[1];
  assign w_cont      = r_ctrl[2];

  // A hop count reduced below the current index mid-frame ends the frame.
  assign w_last = ({1'b0, r_hop_idx_q()} + 1'b1) >= r_num_hops;

  function automatic logic [NHOP_WIDTH-1:0] r_hop_idx_q();
    return hop_idx;
  endfunction

  // Settings values sanitised at write time: zero means one, hop count clamped to table depth.
  always_comb begin
    w_num_new = w_num_sel;
    if (w_num_sel == '0)
      w_num_new = (NHOP_WIDTH+1)'(1);
    else if (w_num_sel > NUM_MAX)
      w_num_new = NUM_MAX;
    w_gap_new = w_gap_sel;
    if (w_gap_sel == '0)
      w_gap_new = CNT_WIDTH'(1);
  end

  // Settings registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_num_hops <= (NHOP_WIDTH+1)'(1);
      r_gap_len  <= CNT_WIDTH'(16384);
    end else begin
      if (w_wr_ctrl) r_ctrl     <= set_data[2:0];
      if (w_wr_num)  r_num_hops <= w_num_new;
      if (w_wr_gap)  r_gap_len  <= w_gap_new;
    end
  end

  // Hop table write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_tbl_hit)
      r_table[w_tbl_idx] <= set_data[PHASE_WIDTH-1:0];
  end

  // Two-flop synchronizer plus registered rising-edge detect on the trigger pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trig_s1  <= 1'b0;
      r_trig_s2  <= 1'b0;
      r_trig_s3  <= 1'b0;
      r_trig_evt <= 1'b0;
    end else begin
      r_trig_s1  <= trig_in;
      r_trig_s2  <= r_trig_s1;
      r_trig_s3  <= r_trig_s2;
      r_trig_evt <= r_trig_s2 & ~r_trig_s3;
    end
  end

  // Next-state selection; clearing enable overrides every state.
  always_comb begin
    w_nxt = r_state;
    if (!w_en) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_nxt = w_trig_mode ? S_ARM : S_GAP;
        S_ARM:  if (r_trig_evt) w_nxt = S_GAP;
        S_GAP:  if (r_cnt == CNT_WIDTH'(1)) w_nxt = S_LOAD;
        S_LOAD: w_nxt = S_HOP;
        S_HOP: begin
          if (hop_ready) begin
            if (!w_last)
              w_nxt = S_GAP;
            else if (w_cont)
              w_nxt = w_trig_mode ? S_ARM : S_GAP;
            else
              w_nxt = S_IDLE;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // State, gap counter, hop index, table read register and registered status outputs.
  // The table read register only loads in LOAD, so it doubles as hop_ph_inc and
  // naturally returns pre-write data on a same-cycle write collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      hop_idx    <= '0;
      hop_ph_inc <= '0;
      frame_done <= 1'b0;
      gen_srst   <= 1'b1;
      tx_active  <= 1'b0;
      sync_out   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_nxt == S_GAP && r_state != S_GAP)
        r_cnt <= r_gap_len;
      else if (r_state == S_GAP)
        r_cnt <= r_cnt - 1'b1;

      if (!w_en)
        hop_idx <= '0;
      else if (r_state == S_HOP && hop_ready)
        hop_idx <= w_last ? '0 : hop_idx + 1'b1;

      if (w_en && r_state == S_LOAD)
        hop_ph_inc <= r_table[hop_idx];

      frame_done <= w_en && (r_state == S_HOP) && hop_ready && w_last;
      gen_srst   <= (w_nxt != S_HOP);
      tx_active  <= (w_nxt == S_HOP);
      sync_out   <= (w_nxt == S_GAP);
      busy       <= (w_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mtx_hop_sched.sv
// Directed bench for mtx_hop_sched: single frame, trigger mode, abort,
// continuous wrap, boundary values, table write collision and mid-frame reset.
module tb_mtx_hop_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        trig_in;
  logic        hop_ready;
  logic        gen_srst;
  logic [23:0] hop_ph_inc;
  logic [5:0]  hop_idx;
  logic        tx_active;
  logic        sync_out;
  logic        frame_done;
  logic        busy;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  mtx_hop_sched #(.PHASE_WIDTH(24), .NHOP_WIDTH(6), .CNT_WIDTH(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .trig_in    (trig_in),
    .hop_ready  (hop_ready),
    .gen_srst   (gen_srst),
    .hop_ph_inc (hop_ph_inc),
    .hop_idx    (hop_idx),
    .tx_active  (tx_active),
    .sync_out   (sync_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    tick();
    set_stb  = 1'b0;
  endtask

  // Wait for HOP, counting ticks and GAP samples on the way.
  task automatic wait_hop(input string tag, input int exp_n, input int exp_g,
                          input logic [5:0] exp_idx, input logic [23:0] exp_ph);
    int n = 0;
    int g = 0;
    while (!tx_active && n < 200) begin
      tick();
      n++;
      if (sync_out) g++;
    end
    chk({tag, "_ticks"}, n, exp_n);
    chk({tag, "_gap"}, g, exp_g);
    chk({tag, "_srst"}, gen_srst, 1'b0);
    chk({tag, "_idx"}, hop_idx, exp_idx);
    chk({tag, "_ph"}, hop_ph_inc, exp_ph);
  endtask

  // Stay 20 cycles in HOP, confirm the increment held, then end the hop.
  task automatic pulse(input string tag, input logic [23:0] exp_ph);
    repeat (19) tick();
    chk({tag, "_ph_hold"}, hop_ph_inc, exp_ph);
    chk({tag, "_tx"}, tx_active, 1'b1);
    hop_ready = 1'b1;
    tick();
    hop_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [23:0] tbl [0:1];
    tbl[0] = 24'h1000;
    tbl[1] = 24'h2000;

    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    trig_in = 1'b0; hop_ready = 1'b0;
    tick(); tick();
    chk("rst_srst", gen_srst, 1'b1);
    chk("rst_ph", hop_ph_inc, 24'h0);
    chk("rst_idx", hop_idx, 6'd0);
    chk("rst_tx", tx_active, 1'b0);
    chk("rst_sync", sync_out, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single frame
    wr(8'd64, 32'h1000);
    wr(8'd65, 32'h2000);
    wr(8'd66, 32'h3000);
    wr(8'd1, 32'd3);
    wr(8'd2, 32'd4);
    wr(8'd0, 32'h1);
    wait_hop("s_h0", 6, 4, 6'd0, 24'h1000);
    pulse("s_h0", 24'h1000);
    chk("s_h0_gap", sync_out, 1'b1);
    wait_hop("s_h1", 5, 3, 6'd1, 24'h2000);
    pulse("s_h1", 24'h2000);
    wait_hop("s_h2", 5, 3, 6'd2, 24'h3000);
    pulse("s_h2", 24'h3000);
    chk("s_fd", frame_done, 1'b1);
    chk("s_busy_end", busy, 1'b0);
    chk("s_srst_end", gen_srst, 1'b1);
    chk("s_idx_end", hop_idx, 6'd0);
    wr(8'd0, 32'h0);
    chk("s_fd_once", frame_done, 1'b0);
    tick();
    chk("s_idle", busy, 1'b0);

    // Trigger mode, second edge during HOP, then abort mid-HOP
    wr(8'd0, 32'h3);
    repeat (10) tick();
    chk("t_arm_busy", busy, 1'b1);
    chk("t_arm_sync", sync_out, 1'b0);
    chk("t_arm_srst", gen_srst, 1'b1);
    trig_in = 1'b1;
    n = 0;
    while (!sync_out && n < 50) begin
      tick();
      n++;
    end
    chk("t_lat", n, 4);
    wait_hop("t_h0", 5, 3, 6'd0, 24'h1000);
    trig_in = 1'b0;
    repeat (3) tick();
    trig_in = 1'b1;
    repeat (6) tick();
    chk("t_edge2_tx", tx_active, 1'b1);
    chk("t_edge2_idx", hop_idx, 6'd0);
    pulse("t_h0", 24'h1000);
    chk("t_h0_idx", hop_idx, 6'd1);
    wait_hop("t_h1", 5, 3, 6'd1, 24'h2000);
    trig_in = 1'b0;
    wr(8'd0, 32'h0);
    tick();
    chk("ab_busy", busy, 1'b0);
    chk("ab_srst", gen_srst, 1'b1);
    chk("ab_idx", hop_idx, 6'd0);
    chk("ab_ph_hold", hop_ph_inc, 24'h2000);

    // Unmapped writes must not disturb table entry 0
    wr(8'd128, 32'h9999);
    wr(8'd3, 32'h8888);

    // Continuous wrap, 3 frames of 2 hops
    wr(8'd1, 32'd2);
    wr(8'd0, 32'h5);
    for (int f = 0; f < 3; f++) begin
      for (int h = 0; h < 2; h++) begin
        wait_hop($sformatf("c_f%0d_h%0d", f, h), (f == 0 && h == 0) ? 6 : 5,
                 (f == 0 && h == 0) ? 4 : 3, 6'(h), tbl[h]);
        pulse($sformatf("c_f%0d_h%0d", f, h), tbl[h]);
        chk($sformatf("c_f%0d_h%0d_fd", f, h), frame_done, (h == 1) ? 1'b1 : 1'b0);
        chk($sformatf("c_f%0d_h%0d_busy", f, h), busy, 1'b1);
      end
    end
    wr(8'd0, 32'h0);
    tick();
    chk("c_idle", busy, 1'b0);

    // Boundaries: zero hop count and zero gap, hop_ready held through GAP/LOAD
    wr(8'd1, 32'd0);
    wr(8'd2, 32'd0);
    wr(8'd0, 32'h1);
    hop_ready = 1'b1;
    tick();
    chk("b_gap", sync_out, 1'b1);
    tick();
    chk("b_load_sync", sync_out, 1'b0);
    chk("b_load_tx", tx_active, 1'b0);
    tick();
    hop_ready = 1'b0;
    chk("b_hop_tx", tx_active, 1'b1);
    chk("b_hop_idx", hop_idx, 6'd0);
    chk("b_hop_ph", hop_ph_inc, 24'h1000);
    pulse("b_h0", 24'h1000);
    chk("b_fd", frame_done, 1'b1);
    chk("b_busy", busy, 1'b0);
    wr(8'd0, 32'h0);
    tick();

    // Write collision on table[1] during LOAD of hop 1
    wr(8'd1, 32'd2);
    wr(8'd2, 32'd4);
    wr(8'd0, 32'h5);
    wait_hop("w_h0", 6, 4, 6'd0, 24'h1000);
    pulse("w_h0", 24'h1000);
    repeat (4) tick();
    chk("w_load_sync", sync_out, 1'b0);
    chk("w_load_tx", tx_active, 1'b0);
    chk("w_load_srst", gen_srst, 1'b1);
    wr(8'd65, 32'hABCD);
    chk("w_old_tx", tx_active, 1'b1);
    chk("w_old_ph", hop_ph_inc, 24'h2000);
    pulse("w_h1", 24'h2000);
    chk("w_fd", frame_done, 1'b1);
    wait_hop("w2_h0", 5, 3, 6'd0, 24'h1000);
    pulse("w2_h0", 24'h1000);
    wait_hop("w2_h1", 5, 3, 6'd1, 24'hABCD);

    // Reset mid-HOP
    reset = 1'b1;
    tick();
    chk("mr_srst", gen_srst, 1'b1);
    chk("mr_ph", hop_ph_inc, 24'h0);
    chk("mr_idx", hop_idx, 6'd0);
    chk("mr_tx", tx_active, 1'b0);
    chk("mr_busy", busy, 1'b0);
    reset = 1'b0;
    tick(); tick();
    chk("mr_stay_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
